// File: rtl/muldiv_unit_pkg.sv
// Shared multiply/divide opcode encodings.
// MD_* values are also decoded by the instruction decoder.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Combinational conditional two's-complement negation.
module cond_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    assign out = neg ? -in : in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO, one bit per cycle.
// MULDIV_EARLY_TERM_EN: divides with b==0 or |a|<|b| skip the iterations.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  muldiv_op_t       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t state, state_n;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, neg_q, neg_r, divz;

    logic accept, is_mul, is_dv, is_sgn, start, early;
    logic sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign accept = req_valid && req_ready && !flush;
    assign is_mul = (req_op == MD_MULT) || (req_op == MD_MULTU);
    assign is_dv  = (req_op == MD_DIV) || (req_op == MD_DIVU);
    assign is_sgn = (req_op == MD_MULT) || (req_op == MD_DIV);
    assign start  = accept && (is_mul || is_dv);
    assign sa     = is_sgn && req_a[WIDTH-1];
    assign sb     = is_sgn && req_b[WIDTH-1];

    cond_negate #(.W(WIDTH)) u_abs_a (.neg(sa), .in(req_a), .out(abs_a));
    cond_negate #(.W(WIDTH)) u_abs_b (.neg(sb), .in(req_b), .out(abs_b));

`ifdef MULDIV_EARLY_TERM_EN
    assign early = is_dv && ((req_b == '0) || (abs_a < abs_b));
`else
    assign early = 1'b0;
`endif

    // One iteration: shift-add for multiply, restoring step for divide.
    logic [WIDTH:0]     mul_sum, trial;
    logic [2*WIDTH-1:0] acc_step;

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, opnd} : '0);
    assign trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

    always_comb begin
        acc_step = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (trial[WIDTH])
                acc_step = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   quot_f, rem_f;

    cond_negate #(.W(2*WIDTH)) u_prod (.neg(neg_q), .in(acc), .out(prod_f));
    cond_negate #(.W(WIDTH)) u_quot (
        .neg(neg_q), .in(acc[WIDTH-1:0]), .out(quot_f)
    );
    cond_negate #(.W(WIDTH)) u_rem (
        .neg(neg_r), .in(acc[2*WIDTH-1:WIDTH]), .out(rem_f)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = early ? SIGN : CALC;
            CALC: begin
                if (flush)         state_n = IDLE;
                else if (cnt == 0) state_n = SIGN;
            end
            SIGN:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            divz   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && req_op == MD_MTHI) begin
                hi   <= req_a;
                done <= 1'b1;
            end
            if (accept && req_op == MD_MTLO) begin
                lo   <= req_a;
                done <= 1'b1;
            end
            if (start) begin
                is_div <= is_dv;
                neg_q  <= sa ^ sb;
                neg_r  <= is_dv && sa;
                divz   <= is_dv && (req_b == '0);
                cnt    <= CW'(WIDTH - 1);
                opnd   <= is_dv ? abs_b : abs_a;
                if (early)      acc <= {abs_a, {WIDTH{1'b0}}};
                else if (is_dv) acc <= {{WIDTH{1'b0}}, abs_a};
                else            acc <= {{WIDTH{1'b0}}, abs_b};
            end
            if (state == CALC && !flush) begin
                acc <= acc_step;
                cnt <= cnt - 1'b1;
            end
            // With b==0 the remainder path already reproduces the raw dividend.
            if (state == SIGN && !flush) begin
                done <= 1'b1;
                if (is_div) begin
                    hi <= rem_f;
                    lo <= divz ? {WIDTH{1'b1}} : quot_f;
                end else begin
                    {hi, lo} <= prod_f;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vectors, random ops vs. arithmetic model.
// Build with MULDIV_EARLY_TERM_EN to expect the short divide latency.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic req_valid = 1'b0;
    logic flush = 1'b0;
    muldiv_op_t req_op = MD_MULT;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic req_ready, busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] m_hl = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .flush(flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_op(muldiv_op_t op, logic [31:0] a,
                                           logic [31:0] b, logic [63:0] cur);
        logic [63:0] p;
        int sa, sb;
        p = cur;
        case (op)
            MD_MULT:  p = longint'($signed(a)) * longint'($signed(b));
            MD_MULTU: p = {32'b0, a} * {32'b0, b};
            MD_DIV: begin
                sa = a;
                sb = b;
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                    p = {32'h0, 32'h80000000};
                else p = {32'(sa % sb), 32'(sa / sb)};
            end
            MD_DIVU: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
            MD_MTHI: p = {a, cur[31:0]};
            MD_MTLO: p = {cur[63:32], a};
            default: p = cur;
        endcase
        return p;
    endfunction

    function automatic int ref_lat(muldiv_op_t op, logic [31:0] a, logic [31:0] b);
        if (op == MD_MTHI || op == MD_MTLO) return 1;
`ifdef MULDIV_EARLY_TERM_EN
        if (op == MD_DIV || op == MD_DIVU) begin
            logic [31:0] ma, mb;
            ma = a;
            mb = b;
            if (op == MD_DIV && a[31]) ma = 32'd0 - a;
            if (op == MD_DIV && b[31]) mb = 32'd0 - b;
            if (b == 0 || ma < mb) return 2;
        end
`endif
        return 34;
    endfunction

    // Caller is positioned at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input muldiv_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int lat, elat;
        bit moved;
        exp  = ref_op(op, a, b, m_hl);
        elat = ref_lat(op, a, b);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: got %b want 1", tag, req_ready);
        end
        req_op = op;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        moved = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (hi !== m_hl[63:32] || lo !== m_hl[31:0]) moved = 1'b1;
        end
        m_hl = exp;
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, elat);
        end
        checks++;
        if (hi !== exp[63:32]) begin
            errors++;
            $display("FAIL %s hi: got %h want %h", tag, hi, exp[63:32]);
        end
        checks++;
        if (lo !== exp[31:0]) begin
            errors++;
            $display("FAIL %s lo: got %h want %h", tag, lo, exp[31:0]);
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL %s hilo_stable: got changed want stable", tag);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({hi, lo} !== 64'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hilo: got %h/%h done=%b want 0/0 done=0", hi, lo, done);
        end
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got ready=%b busy=%b want 1/0", req_ready, busy);
        end
        resetn = 1'b1;
        m_hl = '0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(MD_MULT, 32'hFFFFFFFD, 32'd5, "mult_neg");
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, "div_neg");
        run_op(MD_DIVU, 32'd100, 32'd7, "divu_100_7");
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_op(MD_DIVU, 32'd5, 32'd0, "divu_zero");
        run_op(MD_DIV, 32'hFFFFFFF0, 32'd0, "div_zero_neg");
        run_op(MD_DIV, 32'd3, 32'hFFFFFFF9, "div_small");
        run_op(MD_MTLO, 32'h0BADBEEF, 32'd0, "mtlo");
    endtask

    task automatic test_random();
        muldiv_op_t op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = muldiv_op_t'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 50);
                1: a = 32'h80000000;
                default: ;
            endcase
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 9);
                default: ;
            endcase
            run_op(op, a, b, "random");
        end
    endtask

    task automatic test_flush();
        bit bad;
        run_op(MD_MTHI, 32'h1234, 32'd0, "pre_mthi");
        run_op(MD_MTLO, 32'h5678, 32'd0, "pre_mtlo");
        req_op = MD_MULT;
        req_a = 32'h12345;
        req_b = 32'h777;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || hi !== 32'h1234 || lo !== 32'h5678) bad = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got ready=%b busy=%b want 1/0", req_ready, busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (done || hi !== 32'h1234 || lo !== 32'h5678) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL flush_quiet: got done/hilo change want none");
        end
        run_op(MD_MTHI, 32'hCAFEF00D, 32'd0, "post_flush_mthi");
    endtask

    task automatic test_flush_on_accept();
        req_op = MD_MTLO;
        req_a = 32'hDEAD0000;
        req_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        req_op = MD_MULT;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || lo !== m_hl[31:0] || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_accept: got done=%b lo=%h ready=%b want 0/%h/1",
                     done, lo, req_ready, m_hl[31:0]);
        end
    endtask

    task automatic test_reset_midop();
        run_op(MD_MTHI, 32'h11111111, 32'd0, "pre_reset_mthi");
        req_op = MD_DIVU;
        req_a = 32'hFFFF0000;
        req_b = 32'd3;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if ({hi, lo} !== 64'h0 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: got %h/%h busy=%b ready=%b done=%b want 0/0 0 1 0",
                     hi, lo, busy, req_ready, done);
        end
        m_hl = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_op(MD_MULT, 32'd7, 32'hFFFFFFFE, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_flush_on_accept();
        @(negedge clk);
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
